stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Stack-pointer and stack-access sequencer between the execute and memory stages.
- Accepts push/pop requests of 16-bit or 32-bit width (PC/flags save for CALL/RET/INT).
- Owns SP and drives the memory stage's address, data and read/write strobes.
- 32-bit operations are split into two 16-bit memory cycles; upstream is stalled through a ready handshake.

Parameters:
DATA_W, 16, memory word width
ADDR_W, 16, memory address width
SP_RESET, 16'h0FFF, SP value after reset; top (highest) stack word
STACK_LIMIT, 16'h0F00, lowest address a push may write

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low
req_valid  in  1  request present
req_op  in  2  00 push16, 01 pop16, 10 push32, 11 pop32
req_data  in  32  push data; push16 uses [15:0]
req_ready  out  1  high only in IDLE; request accepted on req_valid&&req_ready at a clock edge
mem_addr  out  16  memory address, registered
mem_wdata  out  16  memory write data, registered
mem_write  out  1  memory write strobe, registered
mem_read  out  1  memory read strobe, registered
mem_rdata  in  16  read data, valid the cycle after mem_read is high
rsp_valid  out  1  one-cycle pulse: pop data available
rsp_data  out  32  pop result; pop16 is zero-extended; holds until next rsp
sp  out  16  current stack pointer
ovf_err  out  1  one-cycle pulse: push rejected
unf_err  out  1  one-cycle pulse: pop rejected

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, sp=SP_RESET. All other outputs are 0, except req_ready, which is 1 from the cycle after reset.
- Reset mid-operation abandons the operation. Any write already issued stays in memory.
- SP points at the next free word. The stack grows down.
- FSM states: IDLE, PUSH_HI, PUSH_LO, POP_RD1, POP_RD2, POP_CAP.
- Accept edge E0; C1 is the first cycle after E0.
- push16: C1 is PUSH_LO: mem_write=1, addr=SP0, wdata=data[15:0], sp=SP0-1. C2 is IDLE.
- push32:
  - C1 PUSH_HI: write data[31:16] @SP0.
  - C2 PUSH_LO: write data[15:0] @SP0-1; sp=SP0-2 from C2.
  - C3 IDLE.
- pop16:
  - C1 POP_CAP-path: mem_read @SP0+1; sp=SP0+1.
  - C2: capture mem_rdata.
  - C3 IDLE: rsp_valid=1, rsp_data={16'h0000, word}.
- pop32:
  - C1 POP_RD1: read @SP0+1.
  - C2 POP_RD2: read @SP0+2; capture low word.
  - C3 POP_CAP: capture high word; sp=SP0+2.
  - C4 IDLE: rsp_valid=1, rsp_data={hi, lo}.
- Strobes are high for exactly one cycle per memory access. mem_read and mem_write are never high together.
- Address arithmetic wraps modulo 2^16.
- A request is never accepted outside IDLE. In particular, a request cannot be accepted in the cycle rsp_valid pulses, because IDLE is entered that cycle and acceptance happens at the following edge.
- Bounds checks (when the Optional Feature is enabled):
  - push16 needs SP0>=STACK_LIMIT.
  - push32 needs SP0>=STACK_LIMIT+1.
  - pop16 needs SP0<SP_RESET.
  - pop32 needs SP0<=SP_RESET-2.
  - On a violation the request is consumed. The block stays in IDLE, issues no memory strobe, leaves sp unchanged, gives no rsp_valid, and pulses ovf_err or unf_err in C1.

Optional Feature:
- Macro STACK_BOUNDS_CHECK_EN.
- Defined: the bounds checks above are applied.
- Undefined: no checks; SP wraps freely; ovf_err and unf_err are tied to 0.

Decomposition:
- Shared package stack_pkg holds:
  - the req_op encodings (OP_PUSH16, OP_POP16, OP_PUSH32, OP_POP32);
  - the FSM state enum;
  - the default SP_RESET and STACK_LIMIT constants.
- One sub-module, stack_bounds_check: combinational. Inputs sp, op, limits; outputs ovf and unf. Instantiated only under STACK_BOUNDS_CHECK_EN.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> sp=0x0FFF, all strobes, rsp_valid and errors 0; req_ready=1 after release.
- Push16 then pop16: push16 0xABCD -> next cycle mem_write=1, addr=0x0FFF, wdata=0xABCD, sp=0x0FFE; then pop16 -> mem_read @0x0FFF, rsp_valid with rsp_data=0x0000ABCD 3 cycles after accept, sp=0x0FFF.
- Push32 then pop32: push32 0x12345678 -> writes 0x1234@0x0FFF then 0x5678@0x0FFE, sp=0x0FFD, req_ready low for 2 cycles; pop32 -> reads @0x0FFE then @0x0FFF, rsp_data=0x12345678 4 cycles after accept.
- Underflow: pop16 right after reset -> unf_err pulse in C1, no mem_read, sp stays 0x0FFF; pop32 at sp=0x0FFE -> unf_err.
- Overflow: preload sp=0x0F00; push32 -> ovf_err, no write; push16 -> write @0x0F00, sp=0x0EFF; next push16 -> ovf_err.
- Reset mid-operation: rst=0 during C1 (PUSH_HI) of push32 -> next cycle IDLE, sp=0x0FFF, low word never written; with the macro undefined, pop16 at reset -> read @0x1000, no error.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: request opcodes, FSM states
// and default stack geometry.
package stack_pkg;

   localparam logic [1:0] OP_PUSH16 = 2'b00;
   localparam logic [1:0] OP_POP16  = 2'b01;
   localparam logic [1:0] OP_PUSH32 = 2'b10;
   localparam logic [1:0] OP_POP32  = 2'b11;

   localparam logic [15:0] DEF_SP_RESET    = 16'h0FFF;
   localparam logic [15:0] DEF_STACK_LIMIT = 16'h0F00;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PUSH_HI = 3'd1,
      PUSH_LO = 3'd2,
      POP_RD1 = 3'd3,
      POP_RD2 = 3'd4,
      POP_CAP = 3'd5
   } state_t;

   // Bit 1 of the opcode selects the 32-bit form of push and pop.
   function automatic logic op_is_32(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/stack_bounds_check.sv
// Combinational stack bounds check: flags a push that would write below the
// limit or a pop that would read above the top-of-stack word.
module stack_bounds_check
   import stack_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] sp,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] stack_limit,
   input  logic [ADDR_W-1:0] sp_reset,
   output logic              ovf,
   output logic              unf
);

   // Widened by one bit so sp+2 cannot wrap around the top of the address space.
   logic [ADDR_W:0] sp_plus2;

   assign sp_plus2 = {1'b0, sp} + (ADDR_W+1)'(2);

   always_comb begin
      ovf = 1'b0;
      unf = 1'b0;
      case (op)
         OP_PUSH16: ovf = (sp < stack_limit);
         OP_PUSH32: ovf = (sp <= stack_limit);
         OP_POP16:  unf = (sp >= sp_reset);
         OP_POP32:  unf = (sp_plus2 > {1'b0, sp_reset});
         default:   ;
      endcase
   end

endmodule

// File: rtl/stack_unit.sv
// Stack-pointer and stack-access sequencer. Optional bounds checking is built
// in when STACK_BOUNDS_CHECK_EN is defined.
module stack_unit
   import stack_pkg::*;
#(
   parameter int                 DATA_W      = 16,
   parameter int                 ADDR_W      = 16,
   parameter logic [ADDR_W-1:0]  SP_RESET    = DEF_SP_RESET,
   parameter logic [ADDR_W-1:0]  STACK_LIMIT = DEF_STACK_LIMIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic [1:0]          req_op,
   input  logic [2*DATA_W-1:0] req_data,
   output logic                req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_write,
   output logic                mem_read,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                rsp_valid,
   output logic [2*DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0]   sp,
   output logic                ovf_err,
   output logic                unf_err
);

   // Handshake: a request transfers at a rising edge where req_valid and
   // req_ready are both high; req_ready is high exactly when the FSM is IDLE.

   state_t state, state_next;

   logic [ADDR_W-1:0]   sp_q, sp_next;
   logic [ADDR_W-1:0]   addr_q, addr_next;
   logic [DATA_W-1:0]   wdata_q, wdata_next;
   logic                write_q, write_next;
   logic                read_q, read_next;
   logic                rsp_valid_q, rsp_valid_next;
   logic [2*DATA_W-1:0] rsp_data_q, rsp_data_next;
   logic                ovf_q, ovf_next;
   logic                unf_q, unf_next;
   logic [DATA_W-1:0]   hold_q, hold_next;
   logic [DATA_W-1:0]   lo_q, lo_next;
   logic                is32_q, is32_next;
   logic                ovf_chk, unf_chk;

`ifdef STACK_BOUNDS_CHECK_EN
   stack_bounds_check #(
      .ADDR_W (ADDR_W)
   ) u_bounds (
      .sp          (sp_q),
      .op          (req_op),
      .stack_limit (STACK_LIMIT),
      .sp_reset    (SP_RESET),
      .ovf         (ovf_chk),
      .unf         (unf_chk)
   );
`else
   logic unused_limit;

   assign unused_limit = ^STACK_LIMIT;
   assign ovf_chk      = 1'b0;
   assign unf_chk      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         sp_q        <= SP_RESET;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         hold_q      <= '0;
         lo_q        <= '0;
         is32_q      <= 1'b0;
      end else begin
         state       <= state_next;
         sp_q        <= sp_next;
         addr_q      <= addr_next;
         wdata_q     <= wdata_next;
         write_q     <= write_next;
         read_q      <= read_next;
         rsp_valid_q <= rsp_valid_next;
         rsp_data_q  <= rsp_data_next;
         ovf_q       <= ovf_next;
         unf_q       <= unf_next;
         hold_q      <= hold_next;
         lo_q        <= lo_next;
         is32_q      <= is32_next;
      end
   end

   // Next-state logic; every memory-side output is computed here and
   // registered above, so strobes appear in the cycle after the decision.
   always_comb begin
      state_next     = state;
      sp_next        = sp_q;
      addr_next      = addr_q;
      wdata_next     = wdata_q;
      write_next     = 1'b0;
      read_next      = 1'b0;
      rsp_valid_next = 1'b0;
      rsp_data_next  = rsp_data_q;
      ovf_next       = 1'b0;
      unf_next       = 1'b0;
      hold_next      = hold_q;
      lo_next        = lo_q;
      is32_next      = is32_q;

      case (state)
         IDLE: begin
            if (req_valid) begin
               is32_next = op_is_32(req_op);
               if (ovf_chk) begin
                  ovf_next = 1'b1;
               end else if (unf_chk) begin
                  unf_next = 1'b1;
               end else begin
                  case (req_op)
                     OP_PUSH16: begin
                        state_next = PUSH_LO;
                        write_next = 1'b1;
                        addr_next  = sp_q;
                        wdata_next = req_data[DATA_W-1:0];
                        sp_next    = sp_q - ADDR_W'(1);
                     end
                     OP_PUSH32: begin
                        state_next = PUSH_HI;
                        write_next = 1'b1;
                        addr_next  = sp_q;
                        wdata_next = req_data[2*DATA_W-1:DATA_W];
                        hold_next  = req_data[DATA_W-1:0];
                     end
                     OP_POP16: begin
                        // Single read shares the tail of the pop32 path.
                        state_next = POP_RD2;
                        read_next  = 1'b1;
                        addr_next  = sp_q + ADDR_W'(1);
                        sp_next    = sp_q + ADDR_W'(1);
                     end
                     default: begin
                        state_next = POP_RD1;
                        read_next  = 1'b1;
                        addr_next  = sp_q + ADDR_W'(1);
                     end
                  endcase
               end
            end
         end
         PUSH_HI: begin
            state_next = PUSH_LO;
            write_next = 1'b1;
            addr_next  = sp_q - ADDR_W'(1);
            wdata_next = hold_q;
            sp_next    = sp_q - ADDR_W'(2);
         end
         PUSH_LO: begin
            state_next = IDLE;
         end
         POP_RD1: begin
            state_next = POP_RD2;
            read_next  = 1'b1;
            addr_next  = sp_q + ADDR_W'(2);
         end
         POP_RD2: begin
            state_next = POP_CAP;
            if (is32_q) begin
               lo_next = mem_rdata;
               sp_next = sp_q + ADDR_W'(2);
            end
         end
         POP_CAP: begin
            state_next     = IDLE;
            rsp_valid_next = 1'b1;
            rsp_data_next  = is32_q ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign req_ready = (state == IDLE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_write = write_q;
   assign mem_read  = read_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign sp        = sp_q;
   assign ovf_err   = ovf_q;
   assign unf_err   = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with a behavioural memory; covers bounds
// behaviour for both STACK_BOUNDS_CHECK_EN settings.
module tb_stack_unit;
   import stack_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_data;
   logic        req_ready;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [15:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [15:0] sp;
   logic        ovf_err;
   logic        unf_err;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int base_cnt;

   logic [15:0] mem [0:65535];

   stack_unit dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_data  (req_data),
      .req_ready (req_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .mem_rdata (mem_rdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .sp        (sp),
      .ovf_err   (ovf_err),
      .unf_err   (unf_err)
   );

   always #5 clk = ~clk;

   // Memory: read data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt        <= wr_cnt + 1;
      end
      if (mem_read) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns one cycle after the accept edge (cycle C1).
   task automatic issue(input logic [1:0] op, input logic [31:0] data);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = data;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!req_ready && n < 8) begin
         step();
         n++;
      end
      check("idle_timeout", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(2);
      rst = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_data  = '0;

      // Reset
      step(2);
      check("rst_sp",        {16'd0, sp}, 32'h0FFF);
      check("rst_write",     {31'd0, mem_write}, 32'd0);
      check("rst_read",      {31'd0, mem_read}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_ovf",       {31'd0, ovf_err}, 32'd0);
      check("rst_unf",       {31'd0, unf_err}, 32'd0);
      rst = 1'b1;
      check("rst_ready",     {31'd0, req_ready}, 32'd1);

      // push16 0xABCD
      issue(OP_PUSH16, 32'h0000ABCD);
      check("p16_write", {31'd0, mem_write}, 32'd1);
      check("p16_addr",  {16'd0, mem_addr}, 32'h0FFF);
      check("p16_wdata", {16'd0, mem_wdata}, 32'hABCD);
      check("p16_sp",    {16'd0, sp}, 32'h0FFE);
      check("p16_ready", {31'd0, req_ready}, 32'd0);
      step();
      check("p16_write_end", {31'd0, mem_write}, 32'd0);
      check("p16_ready_end", {31'd0, req_ready}, 32'd1);

      // pop16
      issue(OP_POP16, 32'h0);
      check("q16_read",  {31'd0, mem_read}, 32'd1);
      check("q16_addr",  {16'd0, mem_addr}, 32'h0FFF);
      check("q16_sp",    {16'd0, sp}, 32'h0FFF);
      check("q16_nowr",  {31'd0, mem_write}, 32'd0);
      step();
      check("q16_c2_rsp",  {31'd0, rsp_valid}, 32'd0);
      check("q16_c2_read", {31'd0, mem_read}, 32'd0);
      step();
      check("q16_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("q16_rsp_data",  rsp_data, 32'h0000ABCD);
      check("q16_ready",     {31'd0, req_ready}, 32'd1);
      step();
      check("q16_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
      check("q16_rsp_hold",  rsp_data, 32'h0000ABCD);

      // push32 0x12345678
      issue(OP_PUSH32, 32'h12345678);
      check("p32_c1_write", {31'd0, mem_write}, 32'd1);
      check("p32_c1_addr",  {16'd0, mem_addr}, 32'h0FFF);
      check("p32_c1_wdata", {16'd0, mem_wdata}, 32'h1234);
      check("p32_c1_sp",    {16'd0, sp}, 32'h0FFF);
      check("p32_c1_ready", {31'd0, req_ready}, 32'd0);
      step();
      check("p32_c2_write", {31'd0, mem_write}, 32'd1);
      check("p32_c2_addr",  {16'd0, mem_addr}, 32'h0FFE);
      check("p32_c2_wdata", {16'd0, mem_wdata}, 32'h5678);
      check("p32_c2_sp",    {16'd0, sp}, 32'h0FFD);
      check("p32_c2_ready", {31'd0, req_ready}, 32'd0);
      step();
      check("p32_c3_write", {31'd0, mem_write}, 32'd0);
      check("p32_c3_ready", {31'd0, req_ready}, 32'd1);

      // pop32
      issue(OP_POP32, 32'h0);
      check("q32_c1_read", {31'd0, mem_read}, 32'd1);
      check("q32_c1_addr", {16'd0, mem_addr}, 32'h0FFE);
      check("q32_c1_sp",   {16'd0, sp}, 32'h0FFD);
      step();
      check("q32_c2_read", {31'd0, mem_read}, 32'd1);
      check("q32_c2_addr", {16'd0, mem_addr}, 32'h0FFF);
      step();
      check("q32_c3_read", {31'd0, mem_read}, 32'd0);
      check("q32_c3_sp",   {16'd0, sp}, 32'h0FFF);
      check("q32_c3_rsp",  {31'd0, rsp_valid}, 32'd0);
      step();
      check("q32_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("q32_rsp_data",  rsp_data, 32'h12345678);

`ifdef STACK_BOUNDS_CHECK_EN
      // Underflow
      issue(OP_POP16, 32'h0);
      check("unf16_err",   {31'd0, unf_err}, 32'd1);
      check("unf16_read",  {31'd0, mem_read}, 32'd0);
      check("unf16_sp",    {16'd0, sp}, 32'h0FFF);
      check("unf16_ready", {31'd0, req_ready}, 32'd1);
      step();
      check("unf16_pulse", {31'd0, unf_err}, 32'd0);
      check("unf16_norsp", {31'd0, rsp_valid}, 32'd0);
      issue(OP_PUSH16, 32'h00001111);
      wait_idle();
      issue(OP_POP32, 32'h0);
      check("unf32_err",  {31'd0, unf_err}, 32'd1);
      check("unf32_read", {31'd0, mem_read}, 32'd0);
      check("unf32_sp",   {16'd0, sp}, 32'h0FFE);
      step();
      issue(OP_POP16, 32'h0);
      step(2);
      check("unf_restore_data", rsp_data, 32'h00001111);
      check("unf_restore_sp",   {16'd0, sp}, 32'h0FFF);
`else
      // Without bounds checks a pop at the top reads past it
      issue(OP_POP16, 32'h0);
      check("wrap16_read", {31'd0, mem_read}, 32'd1);
      check("wrap16_addr", {16'd0, mem_addr}, 32'h1000);
      check("wrap16_unf",  {31'd0, unf_err}, 32'd0);
      check("wrap16_sp",   {16'd0, sp}, 32'h1000);
      wait_idle();
      do_reset();
      check("wrap16_rst_sp", {16'd0, sp}, 32'h0FFF);
`endif

      // Walk SP down to the limit: 127 push32 plus one push16
      for (int i = 0; i < 127; i++) begin
         issue(OP_PUSH32, 32'(i));
         wait_idle();
      end
      issue(OP_PUSH16, 32'h0000FFFF);
      wait_idle();
      check("lim_sp", {16'd0, sp}, 32'h0F00);

`ifdef STACK_BOUNDS_CHECK_EN
      issue(OP_PUSH32, 32'hAAAA5555);
      check("ovf32_err",   {31'd0, ovf_err}, 32'd1);
      check("ovf32_write", {31'd0, mem_write}, 32'd0);
      check("ovf32_sp",    {16'd0, sp}, 32'h0F00);
      step();
      check("ovf32_pulse", {31'd0, ovf_err}, 32'd0);
      issue(OP_PUSH16, 32'h0000BEEF);
      check("lim16_write", {31'd0, mem_write}, 32'd1);
      check("lim16_addr",  {16'd0, mem_addr}, 32'h0F00);
      check("lim16_ovf",   {31'd0, ovf_err}, 32'd0);
      check("lim16_sp",    {16'd0, sp}, 32'h0EFF);
      step();
      issue(OP_PUSH16, 32'h0000CCCC);
      check("ovf16_err",   {31'd0, ovf_err}, 32'd1);
      check("ovf16_write", {31'd0, mem_write}, 32'd0);
      check("ovf16_sp",    {16'd0, sp}, 32'h0EFF);
      step();
`else
      issue(OP_PUSH32, 32'hAAAA5555);
      check("free32_c1_addr", {16'd0, mem_addr}, 32'h0F00);
      check("free32_c1_data", {16'd0, mem_wdata}, 32'hAAAA);
      check("free32_ovf",     {31'd0, ovf_err}, 32'd0);
      step();
      check("free32_c2_addr", {16'd0, mem_addr}, 32'h0EFF);
      check("free32_c2_data", {16'd0, mem_wdata}, 32'h5555);
      check("free32_sp",      {16'd0, sp}, 32'h0EFE);
      step();
`endif

      // Reset during PUSH_HI abandons the low-word write
      do_reset();
      check("mid_pre_sp", {16'd0, sp}, 32'h0FFF);
      base_cnt = wr_cnt;
      issue(OP_PUSH32, 32'hCAFEF00D);
      check("mid_c1_write", {31'd0, mem_write}, 32'd1);
      check("mid_c1_addr",  {16'd0, mem_addr}, 32'h0FFF);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("mid_write",  {31'd0, mem_write}, 32'd0);
      check("mid_sp",     {16'd0, sp}, 32'h0FFF);
      check("mid_ready",  {31'd0, req_ready}, 32'd1);
      step(2);
      check("mid_no_lo",  {31'd0, mem_write}, 32'd0);
      check("mid_wr_cnt", 32'(wr_cnt - base_cnt), 32'd1);
      check("mid_hi_mem", {16'd0, mem[16'h0FFF]}, 32'hCAFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
